// File: rtl/muldiv_pkg.sv
// Shared encodings and decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // Whether the selected operand (rs1 when second_op=0, rs2 otherwise) is two's complement.
    function automatic logic is_signed(input logic [2:0] f3, input logic second_op);
        case (f3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: return 1'b1;
            F3_MULHSU:                       return !second_op;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step on {acc, opr}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      f3,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] opr,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] acc_next,
    output logic [XLEN-1:0] opr_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum      = {1'b0, acc} + (opr[0] ? {1'b0, operand} : '0);
        shifted  = {acc, opr[XLEN-1]};
        diff     = shifted - {1'b0, operand};
        acc_next = sum[XLEN:1];
        opr_next = {sum[0], opr[XLEN-1:1]};
        if (is_div(f3)) begin
            // Partial remainder stays below the divisor, so diff's top bit is a clean borrow flag.
            acc_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            opr_next = {opr[XLEN-2:0], ~diff[XLEN]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: magnitudes iterate one bit per cycle, signs are fixed up on completion.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nx;
    logic [CW-1:0]     count;
    logic [XLEN-1:0]   acc, opr, opb;
    logic [2:0]        f3_r;
    logic [4:0]        rd_r;
    logic              neg_q, neg_r;
    logic [XLEN-1:0]   acc_step, opr_step;

    logic              sa, sb, special, issue;
    logic [XLEN-1:0]   abs_a, abs_b, special_res;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix, final_res;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .f3       (f3_r),
        .acc      (acc),
        .opr      (opr),
        .operand  (opb),
        .acc_next (acc_step),
        .opr_next (opr_step)
    );

    always_comb begin
        sa      = is_signed(funct3, 1'b0) & rs1_val[XLEN-1];
        sb      = is_signed(funct3, 1'b1) & rs2_val[XLEN-1];
        abs_a   = sa ? -rs1_val : rs1_val;
        abs_b   = sb ? -rs2_val : rs2_val;
        issue   = (state == ST_IDLE) && start && !kill;
        special = 1'b0;
        special_res = '0;
        if (is_div(funct3)) begin
            if (rs2_val == '0) begin
                special     = 1'b1;
                special_res = funct3[1] ? rs1_val : '1;
            end else if (!funct3[0] && rs1_val == MIN_INT && rs2_val == '1) begin
                special     = 1'b1;
                special_res = funct3[1] ? '0 : MIN_INT;
            end
        end
    end

    // Final step outputs feed the fix-up directly so the result is ready on the BUSY->DONE edge.
    always_comb begin
        prod_fix  = neg_q ? -{acc_step, opr_step} : {acc_step, opr_step};
        q_fix     = neg_q ? -opr_step : opr_step;
        r_fix     = neg_r ? -acc_step : acc_step;
        if (is_div(f3_r))
            final_res = f3_r[1] ? r_fix : q_fix;
        else
            final_res = (f3_r[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (issue) state_nx = special ? ST_DONE : ST_BUSY;
            ST_BUSY: begin
                if (kill)                 state_nx = ST_IDLE;
                else if (count == CW'(1)) state_nx = ST_DONE;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_DONE) && !kill;
    assign wb_we = done && (wb_rd != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            acc     <= '0;
            opr     <= '0;
            opb     <= '0;
            f3_r    <= '0;
            rd_r    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else if (issue) begin
            count <= CW'(XLEN);
            acc   <= '0;
            opr   <= abs_a;
            opb   <= abs_b;
            f3_r  <= funct3;
            rd_r  <= rd_in;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            if (special) begin
                wb_data <= special_res;
                wb_rd   <= rd_in;
            end
        end else if (state == ST_BUSY && !kill) begin
            acc   <= acc_step;
            opr   <= opr_step;
            count <= count - CW'(1);
            if (count == CW'(1)) begin
                wb_data <= final_res;
                wb_rd   <= rd_r;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner sequences, random ops vs. a 64-bit arithmetic model.
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam int NORMAL_LAT = 33;

    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val;
    logic [4:0]  rd_in;
    logic        busy, done, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .kill    (kill),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_in   (rd_in),
        .busy    (busy),
        .done    (done),
        .wb_we   (wb_we),
        .wb_rd   (wb_rd),
        .wb_data (wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // RISC-V M semantics computed with plain 64-bit and native int arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      sa64, sb64, ub64;
        logic [63:0] p;
        sa = a;
        sb = b;
        sa64 = longint'(sa);
        sb64 = longint'(sb);
        ub64 = longint'({32'b0, b});
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa64 * sb64; return p[63:32]; end
            3'd2: begin p = sa64 * ub64; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return NORMAL_LAT;
    endfunction

    task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                         input int exp_lat);
        int          cyc;
        bit          seen, busy_bad, we_bad;
        logic [31:0] got_data;
        logic [4:0]  got_rd;
        logic        got_we;
        @(negedge clk);
        start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b; rd_in = rd;
        @(posedge clk);
        #1;
        start = 1'b0;
        funct3 = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom; rd_in = 5'($urandom);
        cyc = 0; seen = 0; busy_bad = 0; we_bad = 0;
        got_data = '0; got_rd = '0; got_we = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (!busy) busy_bad = 1;
            if (wb_we && !done) we_bad = 1;
            if (done) begin
                seen = 1;
                got_data = wb_data; got_rd = wb_rd; got_we = wb_we;
            end
        end
        check({name, "_done_seen"}, 64'(seen), 64'(1));
        check({name, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({name, "_wb_data"}, 64'(got_data), 64'(exp));
        check({name, "_wb_rd"}, 64'(got_rd), 64'(rd));
        check({name, "_wb_we"}, 64'(got_we), 64'(rd != 5'd0));
        check({name, "_busy_held"}, 64'(busy_bad), 64'(0));
        check({name, "_we_outside_done"}, 64'(we_bad), 64'(0));
        @(negedge clk);
        check({name, "_done_single"}, 64'(done), 64'(0));
        check({name, "_idle_after"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int          dones;
        logic [31:0] first_data;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        logic [4:0]  rrd;

        rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0;
        rs1_val = '0; rs2_val = '0; rd_in = '0;

        vecs.push_back('{"mul_7x-3",     3'd0, 32'h7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33});
        vecs.push_back('{"mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33});
        vecs.push_back('{"mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000, 5'd7,  32'h4000_0000, 33});
        vecs.push_back('{"mulhsu_m1",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 33});
        vecs.push_back('{"div_-7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 33});
        vecs.push_back('{"rem_-7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 33});
        vecs.push_back('{"divu_100_7",   3'd5, 32'd100,        32'd7,         5'd11, 32'd14,        33});
        vecs.push_back('{"remu_100_7",   3'd7, 32'd100,        32'd7,         5'd12, 32'd2,         33});
        vecs.push_back('{"div_by_zero",  3'd4, 32'h1234,       32'd0,         5'd13, 32'hFFFF_FFFF, 1});
        vecs.push_back('{"rem_by_zero",  3'd6, 32'h1234,       32'd0,         5'd14, 32'h1234,      1});
        vecs.push_back('{"div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1});
        vecs.push_back('{"rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0,         1});
        vecs.push_back('{"divu_by_zero", 3'd5, 32'd5,          32'd0,         5'd17, 32'hFFFF_FFFF, 1});
        vecs.push_back('{"mul_rd0",      3'd0, 32'd3,          32'd4,         5'd0,  32'd12,        33});

        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_wb_we", 64'(wb_we), 64'(0));
        check("reset_wb_rd", 64'(wb_rd), 64'(0));
        check("reset_wb_data", 64'(wb_data), 64'(0));
        rst = 1'b0;

        foreach (vecs[i])
            do_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat);

        // start held high through BUSY: exactly one completion, operands of the first issue only.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; rs1_val = 32'd6; rs2_val = 32'd7; rd_in = 5'd3;
        dones = 0; first_data = '0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (c == 0) begin rs1_val = 32'd100; rs2_val = 32'd100; end
            if (done) begin
                dones++;
                if (dones == 1) first_data = wb_data;
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("start_hold_done_count", 64'(dones), 64'(1));
        check("start_hold_data", 64'(first_data), 64'(42));

        // kill mid-BUSY
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd4;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1 kill = 1'b0;
        @(negedge clk);
        check("kill_busy_idle", 64'(busy), 64'(0));
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || wb_we) dones++;
        end
        check("kill_busy_no_done", 64'(dones), 64'(0));

        // kill while in DONE suppresses the pulse
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; rs1_val = 32'h55; rs2_val = 32'd0; rd_in = 5'd9;
        @(posedge clk); #1 start = 1'b0; kill = 1'b1;
        @(negedge clk);
        check("kill_done_done", 64'(done), 64'(0));
        check("kill_done_we", 64'(wb_we), 64'(0));
        @(posedge clk); #1 kill = 1'b0;
        @(negedge clk);
        check("kill_done_idle", 64'(busy), 64'(0));

        // kill and start together in IDLE: nothing issued
        @(negedge clk);
        start = 1'b1; kill = 1'b1; funct3 = 3'd0; rs1_val = 32'd2; rs2_val = 32'd2; rd_in = 5'd1;
        @(posedge clk); #1 start = 1'b0; kill = 1'b0;
        @(negedge clk);
        check("kill_start_busy", 64'(busy), 64'(0));
        check("kill_start_done", 64'(done), 64'(0));

        // async reset between edges mid-BUSY
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; rs1_val = 32'd9; rs2_val = 32'd9; rd_in = 5'd2;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        check("arst_wb_we", 64'(wb_we), 64'(0));
        check("arst_wb_rd", 64'(wb_rd), 64'(0));
        check("arst_wb_data", 64'(wb_data), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        do_op("after_reset", 3'd4, 32'hFFFF_FF9C, 32'd7, 5'd20, 32'hFFFF_FFF2, 33);

        // random ops against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            rrd = 5'($urandom);
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                3: rb = -32'($urandom_range(1, 20));
                default: ;
            endcase
            do_op($sformatf("rand%0d_f3_%0d", n, rf3), rf3, ra, rb, rrd,
                  model(rf3, ra, rb), model_lat(rf3, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
